// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   Each digit slot is PRESCALE cycles: BLANK_CYCLES with all anodes off (the
//   external decoder settles on nibble_out meanwhile), then the selected anode
//   is driven low for the rest of the slot. New values are staged in a pending
//   register and only committed at the frame boundary, so a frame never tears.
//
//   Optional feature macro: HEXDISP_LZB_EN (leading-zero blanking).
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   value_in     : hex value, nibble k -> digit k (digit 0 least significant)
//   dp_in        : per-digit decimal point request, active-high
//   load         : one-cycle strobe capturing value_in/dp_in
//   nibble_out   : current digit nibble, to the external decoder
//   seg_in       : decoder output, active-low {dp, g..a}
//   seg_out      : registered active-low segment drive
//   digit_an     : registered active-low anode enables
//   frame_done   : one-cycle pulse at the start of each new frame
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 12000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [3:0]              nibble_out,
  input  logic [7:0]              seg_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic                    frame_done
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {ST_BLANK, ST_ON} state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   disp_val_q, pend_val_q;
  logic [NUM_DIGITS-1:0]        disp_dp_q, pend_dp_q;
  logic                         pend_vld_q;
  logic [7:0]                   seg_q, seg_d;
  logic [NUM_DIGITS-1:0]        an_q, an_d;
  logic                         fd_q;
  logic                         wrap;
  logic                         show;

  assign nibble_out = disp_val_q[idx_q];
  assign seg_out    = seg_q;
  assign digit_an   = an_q;
  assign frame_done = fd_q;

`ifdef HEXDISP_LZB_EN
  // lz[k]: digit k and every digit above it are zero with no dp requested.
  logic [NUM_DIGITS-1:0] lz, blank;
  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_lz
      logic zero_k;
      assign zero_k = (disp_val_q[k] == 4'h0) && !disp_dp_q[k];
      if (k == NUM_DIGITS-1) begin : g_top
        assign lz[k] = zero_k;
      end else begin : g_mid
        assign lz[k] = zero_k && lz[k+1];
      end
      // Digit 0 is always shown so an all-zero value still reads "0".
      if (k == 0) begin : g_d0
        assign blank[k] = 1'b0;
      end else begin : g_dk
        assign blank[k] = lz[k];
      end
    end
  endgenerate
  assign show = !blank[idx_q];
`else
  assign show = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES-1)) state_d = ST_ON;
      end
      ST_ON: begin
        if (cnt_q == CNT_W'(PRESCALE-1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_W'(NUM_DIGITS-1)) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    // idx is unchanged whenever the next state is ON.
    seg_d = 8'hFF;
    an_d  = '1;
    if (state_d == ST_ON && show) begin
      an_d[idx_q] = 1'b0;
      seg_d       = seg_in;
      if (disp_dp_q[idx_q]) seg_d[7] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= 8'hFF;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fd_q    <= wrap;
      if (load) begin
        pend_val_q <= value_in;
        pend_dp_q  <= dp_in;
      end
      if (wrap) begin
        // A load landing on the boundary itself is newer than anything pending.
        pend_vld_q <= 1'b0;
        if (load) begin
          disp_val_q <= value_in;
          disp_dp_q  <= dp_in;
        end else if (pend_vld_q) begin
          disp_val_q <= pend_val_q;
          disp_dp_q  <= pend_dp_q;
        end
      end else if (load) begin
        pend_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
module tb_hex_display_scanner;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  nibble_out;
  logic [7:0]  seg_in;
  logic [7:0]  seg_out;
  logic [3:0]  digit_an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  hex_display_scanner #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .load(load),
    .nibble_out(nibble_out), .seg_in(seg_in), .seg_out(seg_out),
    .digit_an(digit_an), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural decoder, active-low g..a, dp off.
  function automatic logic [7:0] dseg(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40; 4'h1: p = 7'h79; 4'h2: p = 7'h24; 4'h3: p = 7'h30;
      4'h4: p = 7'h19; 4'h5: p = 7'h12; 4'h6: p = 7'h02; 4'h7: p = 7'h78;
      4'h8: p = 7'h00; 4'h9: p = 7'h10; 4'hA: p = 7'h08; 4'hB: p = 7'h03;
      4'hC: p = 7'h46; 4'hD: p = 7'h21; 4'hE: p = 7'h06; default: p = 7'h0E;
    endcase
    return {1'b1, p};
  endfunction

  always_comb seg_in = dseg(nibble_out);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic go(input int n);
    while (t < n) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; value_in = '0; dp_in = '0; load = 1'b0;
    #22;
    chk("rst_seg", 16'(seg_out), 16'h00FF);
    chk("rst_an", 16'(digit_an), 16'h000F);
    chk("rst_fd", 16'(frame_done), 16'h0);
    chk("rst_nib", 16'(nibble_out), 16'h0);
    #1 rst_n = 1'b1;
    t = 0;

    // Load 12A4 during frame 1: frame 1 still shows zeros.
    do_load(16'h12A4, 4'b0000);
    chk("f1_blank_an", 16'(digit_an), 16'h000F);
    go(2);  chk("f1_d0_an", 16'(digit_an), 16'h000E);
            chk("f1_d0_seg", 16'(seg_out), 16'(dseg(4'h0)));
    go(7);  chk("f1_d0_end", 16'(digit_an), 16'h000E);
    go(8);  chk("f1_d1_blank", 16'(digit_an), 16'h000F);
    go(10); chk("f1_d1_an", 16'(digit_an), 16'h000D);
            chk("f1_d1_seg", 16'(seg_out), 16'(dseg(4'h0)));
    go(31); chk("f1_fd_lo", 16'(frame_done), 16'h0);
    go(32); chk("f2_fd", 16'(frame_done), 16'h1);
            chk("f2_blank_an", 16'(digit_an), 16'h000F);
            chk("f2_blank_seg", 16'(seg_out), 16'h00FF);
            chk("f2_nib", 16'(nibble_out), 16'h4);
    go(33); chk("f2_fd_lo", 16'(frame_done), 16'h0);
    go(34); chk("f2_d0_an", 16'(digit_an), 16'h000E);
            chk("f2_d0_seg", 16'(seg_out), 16'(dseg(4'h4)));
    go(42); chk("f2_d1_an", 16'(digit_an), 16'h000D);
            chk("f2_d1_seg", 16'(seg_out), 16'(dseg(4'hA)));
    go(50); chk("f2_d2_an", 16'(digit_an), 16'h000B);
            chk("f2_d2_seg", 16'(seg_out), 16'(dseg(4'h2)));
    go(58); chk("f2_d3_an", 16'(digit_an), 16'h0007);
            chk("f2_d3_seg", 16'(seg_out), 16'(dseg(4'h1)));
    go(64); chk("f3_fd", 16'(frame_done), 16'h1);

    // Two loads mid-frame: the later one wins, nothing changes until the boundary.
    go(69); do_load(16'h5555, 4'b0000);
    go(74); chk("f3_d1_hold", 16'(seg_out), 16'(dseg(4'hA)));
    go(79); do_load(16'h0F0F, 4'b0000);
    go(90); chk("f3_d3_hold", 16'(seg_out), 16'(dseg(4'h1)));
    go(96); chk("f4_fd", 16'(frame_done), 16'h1);
            chk("f4_nib", 16'(nibble_out), 16'hF);
    go(98);  chk("f4_d0_seg", 16'(seg_out), 16'(dseg(4'hF)));
    go(106); chk("f4_d1_seg", 16'(seg_out), 16'(dseg(4'h0)));
    go(114); chk("f4_d2_seg", 16'(seg_out), 16'(dseg(4'hF)));
    go(122); chk("f4_d3_seg", 16'(seg_out), 16'(dseg(4'h0)));

    // Load on the wrap edge goes straight to the display.
    go(127); do_load(16'hBEEF, 4'b0000);
    chk("wrap_fd", 16'(frame_done), 16'h1);
    chk("wrap_nib", 16'(nibble_out), 16'hF);
    chk("wrap_pvld", 16'(dut.pend_vld_q), 16'h0);
    go(130); chk("f5_d0_seg", 16'(seg_out), 16'(dseg(4'hF)));
    go(138); chk("f5_d1_seg", 16'(seg_out), 16'(dseg(4'hE)));

    // Decimal point on digit 2, effective next frame.
    go(139); do_load(16'hBEEF, 4'b0100);
    go(146); chk("f5_d2_nodp", 16'(seg_out), 16'(dseg(4'hE)));
    go(154); chk("f5_d3_seg", 16'(seg_out), 16'(dseg(4'hB)));
    go(162); chk("dp_d0_seg", 16'(seg_out), 16'(dseg(4'hF)));
    go(169); do_load(16'h1234, 4'b0000);  // left pending across the reset below
    go(170); chk("dp_d1_seg", 16'(seg_out), 16'(dseg(4'hE)));
    go(176); chk("dp_blank_seg", 16'(seg_out), 16'h00FF);
    go(178); chk("dp_d2_an", 16'(digit_an), 16'h000B);
             chk("dp_d2_seg", 16'(seg_out), 16'(dseg(4'hE) & 8'h7F));
    go(180);

    // Reset mid-ON.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 16'(digit_an), 16'h000F);
    chk("mid_rst_seg", 16'(seg_out), 16'h00FF);
    chk("mid_rst_nib", 16'(nibble_out), 16'h0);
    #4 rst_n = 1'b1;
    t = 0;
    go(2);  chk("rr_d0_an", 16'(digit_an), 16'h000E);
            chk("rr_d0_seg", 16'(seg_out), 16'(dseg(4'h0)));
    go(32); chk("rr_fd", 16'(frame_done), 16'h1);
    go(34); chk("rr_f2_seg", 16'(seg_out), 16'(dseg(4'h0)));

    // Leading-zero blanking (or its absence in the default build).
    go(39); do_load(16'h0030, 4'b0000);
    go(58); chk("rr_f2_d3", 16'(seg_out), 16'(dseg(4'h0)));
    go(66); chk("lz_d0_an", 16'(digit_an), 16'h000E);
            chk("lz_d0_seg", 16'(seg_out), 16'(dseg(4'h0)));
    go(74); chk("lz_d1_an", 16'(digit_an), 16'h000D);
            chk("lz_d1_seg", 16'(seg_out), 16'(dseg(4'h3)));
`ifdef HEXDISP_LZB_EN
    go(82); chk("lz_d2_an", 16'(digit_an), 16'h000F);
    go(90); chk("lz_d3_an", 16'(digit_an), 16'h000F);
`else
    go(82); chk("nolz_d2_an", 16'(digit_an), 16'h000B);
            chk("nolz_d2_seg", 16'(seg_out), 16'(dseg(4'h0)));
    go(90); chk("nolz_d3_an", 16'(digit_an), 16'h000F & 16'h0007);
`endif
    go(91); do_load(16'h0000, 4'b1000);
    go(98);  chk("dpz_d0_an", 16'(digit_an), 16'h000E);
    go(114); chk("dpz_d2_an", 16'(digit_an), 16'h000B);
    go(122); chk("dpz_d3_an", 16'(digit_an), 16'h0007);
             chk("dpz_d3_seg", 16'(seg_out), 16'(dseg(4'h0) & 8'h7F));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed driver for an N-digit common-anode seven-segment display. Holds a hex value, walks one digit at a time at a prescaled refresh rate, presents the selected nibble to the downstream `nibble_to_seven_seg` decoder, takes the active-low segment pattern back, and drives the registered segment bus and active-low digit anodes. Sits between the design's data registers and the display pins, with a blanking interval between digits to suppress ghosting and tear-free frame-boundary updates.

## Interface
- `NUM_DIGITS`, 4: digits scanned; 1..8.
- `PRESCALE`, 12000: clk cycles per digit slot; must exceed `BLANK_CYCLES`.
- `BLANK_CYCLES`, 64: cycles at the start of each slot with all anodes off; ≥1.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `value_in` in 4*NUM_DIGITS: hex value; nibble k shows on digit k, where digit 0 is least significant.
- `dp_in` in NUM_DIGITS: decimal point request per digit, active-high.
- `load` in 1: one-cycle strobe capturing `value_in`/`dp_in`.
- `nibble_out` out 4: nibble of the current digit, combinational from internal registers, to decoder.
- `seg_in` in 8: decoder output, active-low; bit 7 = dp, bits 6:0 = g..a.
- `seg_out` out 8: registered active-low segment drive.
- `digit_an` out NUM_DIGITS: registered active-low anode enables; at most one low.
- `frame_done` out 1: one-cycle pulse when the last digit slot ends.

## Operation
- Registers: `pend` (value+dp), `pend_vld`, `disp` (value+dp), `idx` (digit index), `cnt` (slot counter), state.
- `load` → `pend` ← inputs, `pend_vld` ← 1. The most recent load before commit wins.
- Commit occurs at the slot boundary where `idx` wraps from NUM_DIGITS-1 to 0:
  - If `pend_vld`, then `disp` ← `pend` and `pend_vld` ← 0.
  - If `load` is asserted in that same cycle, `value_in`/`dp_in` go straight to `disp`, and `pend_vld` ends 0.
- States:
  - BLANK: `cnt` counts 0..BLANK_CYCLES-1. `digit_an` = all 1, `seg_out` = 8'hFF. After the last count → ON.
  - ON: `cnt` continues to PRESCALE-1. `digit_an[idx]` = 0. `seg_out` = `seg_in`, with bit 7 forced to 0 if `disp.dp[idx]`. At the end of the slot → BLANK, `cnt` ← 0, `idx` ← idx+1, wrapping to 0; the wrap pulses `frame_done` and commits.
- `nibble_out` = `disp.value[4*idx+3 -: 4]` at all times, so the decoder settles during BLANK.
- Frame length = NUM_DIGITS*PRESCALE cycles.

## Timing
- Reset values:
  - `seg_out` = 8'hFF, `digit_an` = all 1, `frame_done` = 0, `nibble_out` = 0.
  - Internal: `idx` = 0, `cnt` = 0, state BLANK, `disp` = 0, `pend` = 0, `pend_vld` = 0.
- First anode goes low at cycle BLANK_CYCLES after reset release, and stays low PRESCALE-BLANK_CYCLES cycles.
- `seg_out`/`digit_an` are registered in the same cycle; `seg_out` reflects `seg_in` with one cycle of latency.
- `frame_done` is high in the cycle the BLANK state for digit 0 begins, i.e. the first cycle with updated `disp`.
- A load mid-frame never changes the displayed value until the next frame.
- Reset asserted mid-slot: all outputs return to reset values immediately, and pending data is discarded.

## Configuration
- `HEXDISP_LZB_EN` defined: leading-zero blanking.
  - Scanning from NUM_DIGITS-1 downward, a digit whose nibble is 0 and whose dp bit is 0 keeps its anode high during ON, until the first nonzero or dp digit is reached.
  - Digit 0 is always shown.
  - Slot timing is unchanged.
- Undefined: all digits are always shown; no blanking logic is synthesized.

## Test plan
Bench parameters: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, and a behavioural decoder on `nibble_out`→`seg_in`.
- Reset, then `load` 16'h12A4, dp=0 → first frame shows 0 on all digits. From frame 2: `digit_an` sequence 1110,1101,1011,0111, each low for 6 cycles after 2 blank cycles. `seg_out` = decode(4), decode(A), decode(2), decode(1). `frame_done` pulses every 32 cycles.
- `load` 16'h5555 mid-frame, then 16'h0F0F before the boundary → 16'h0F0F displayed next frame; 16'h5555 never appears.
- `load` coincident with the wrap cycle, value 16'hBEEF → `disp` = 16'hBEEF in that frame; `pend_vld` = 0 afterwards.
- `dp_in` = 4'b0100 → `seg_out[7]` = 0 only while `digit_an` = 1011.
- Reset asserted mid-ON → `digit_an` all 1 and `seg_out` = 8'hFF in the same cycle. After release, the scan restarts at digit 0 with `disp` = 0.
- With `HEXDISP_LZB_EN`, `load` 16'h0030 → digits 3 and 2 are never enabled, and digits 1 and 0 show 3 and 0. With dp_in = 4'b1000 and value 16'h0000 → all digits are enabled.
